// File: rtl/cska_result_stage.sv
// Registered result stage for the 32-bit carry-skip adder: derives V/C/N/Z,
// queues {sum,flags} in a small FIFO and counts signed-overflow events.
//
// Ports: clk, rst_n (sync, active-low)
//   in_valid/in_ready  : upstream handshake for op_a, op_b, sum, cout
//   out_valid/out_ready: downstream handshake for out_sum, out_flags {V,C,N,Z}
//   level              : FIFO occupancy
//   ovf_count/clr_count: saturating V=1 push counter and its clear
module cska_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         op_a,
  input  logic [WIDTH-1:0]         op_b,
  input  logic [WIDTH-1:0]         sum,
  input  logic                     cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         ovf_count,
  input  logic                     clr_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_PART  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [WIDTH-1:0] sum_q [DEPTH];
  logic [3:0]       flg_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [1:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic push, pop;
  logic f_v, f_c, f_n, f_z;
  logic [3:0] flags;

  // Overflow from sign bits only; the operands are never re-added.
  assign f_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &
                 (sum[WIDTH-1] != op_a[WIDTH-1]);
  assign f_c   = cout;
  assign f_n   = sum[WIDTH-1];
  assign f_z   = (sum == '0);
  assign flags = {f_v, f_c, f_n, f_z};

  assign in_ready  = (lvl_q != LW'(DEPTH));
  assign out_valid = (st_q != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_sum   = sum_q[rd_q];
  assign out_flags = flg_q[rd_q];
  assign level     = lvl_q;
  assign ovf_count = cnt_q;

  always_comb begin
    lvl_d = lvl_q;
    unique case ({push, pop})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_EMPTY: if (push) st_d = ST_PART;
      ST_PART: begin
        if (push && !pop && lvl_q == LW'(DEPTH - 1))
          st_d = ST_FULL;
        else if (pop && !push && lvl_q == LW'(1))
          st_d = ST_EMPTY;
      end
      ST_FULL:  if (pop) st_d = ST_PART;
      default:  st_d = ST_EMPTY;
    endcase
  end

  // Clear wins over a same-cycle increment; count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_count)
      cnt_d = '0;
    else if (push && f_v && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      st_q  <= ST_EMPTY;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sum_q[i] <= '0;
        flg_q[i] <= '0;
      end
    end else begin
      lvl_q <= lvl_d;
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (push) begin
        sum_q[wr_q] <= sum;
        flg_q[wr_q] <= flags;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop)
        rd_q <= rd_q + PW'(1);
    end
  end

endmodule
